// File: rtl/hack_loader_pkg.sv
// Shared definitions for the Hack SoC ROM loader: register map, bit indices,
// ROM handshake state encoding and the held ROM word payload.
package hack_loader_pkg;

    localparam int unsigned WB_DW  = 32;
    localparam int unsigned ROM_AW = 15;
    localparam int unsigned ROM_DW = 16;
    localparam int unsigned TO_CW  = 8;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_SOC_RESET = 0;
    localparam int unsigned CTRL_LOAD_MODE = 1;
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_TIMEOUT   = 1;

    localparam logic [1:0] CTRL_RESET_VAL = 2'b01;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_REQ  = 1'b1
    } rom_state_t;

    typedef struct packed {
        logic [ROM_AW-1:0] addr;
        logic [ROM_DW-1:0] data;
    } rom_word_t;

endpackage

// File: rtl/hack_loader_rom_if.sv
// ROM load handshake: holds one word request until the SoC acks it.
// Optional ack timeout is compiled in with HACK_LOADER_TIMEOUT_EN.
module hack_loader_rom_if
    import hack_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    input  rom_word_t word_in,
    input  logic      rom_ack,
    output logic      busy,
    output logic      req,
    output rom_word_t word,
    output logic      done_c,
    output logic      timeout_c
);

    rom_state_t state, state_d;
    logic       req_d;
    rom_word_t  word_d;

`ifdef HACK_LOADER_TIMEOUT_EN
    localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TIMEOUT_CYCLES - 1);
    logic [TO_CW-1:0] cnt, cnt_d;
`else
    logic unused_ok;
    assign unused_ok = ^TO_CW'(TIMEOUT_CYCLES);
`endif

    assign busy = (state == R_REQ);

    // State and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= R_IDLE;
            req   <= 1'b0;
            word  <= '0;
`ifdef HACK_LOADER_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_d;
            req   <= req_d;
            word  <= word_d;
`ifdef HACK_LOADER_TIMEOUT_EN
            cnt   <= cnt_d;
`endif
        end
    end

    // Next state; word is only captured on entry so it stays stable in R_REQ
    always_comb begin
        state_d   = state;
        req_d     = req;
        word_d    = word;
        done_c    = 1'b0;
        timeout_c = 1'b0;
`ifdef HACK_LOADER_TIMEOUT_EN
        cnt_d     = cnt;
`endif
        case (state)
            R_IDLE: begin
                if (start) begin
                    state_d = R_REQ;
                    req_d   = 1'b1;
                    word_d  = word_in;
`ifdef HACK_LOADER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            R_REQ: begin
                if (rom_ack) begin
                    state_d = R_IDLE;
                    req_d   = 1'b0;
                    done_c  = 1'b1;
`ifdef HACK_LOADER_TIMEOUT_EN
                end else if (cnt == TO_LAST) begin
                    state_d   = R_IDLE;
                    req_d     = 1'b0;
                    timeout_c = 1'b1;
                end else begin
                    cnt_d = cnt + TO_CW'(1);
`endif
                end
            end
            default: begin
                state_d = R_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_hack_loader.sv
// Wishbone slave register window that loads Hack SoC ROM words one at a time.
// Define HACK_LOADER_TIMEOUT_EN to enable the ROM-ack timeout and STATUS[1].
module wb_hack_loader
    import hack_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [WB_DW-1:0]  wbs_adr_i,
    input  logic [WB_DW-1:0]  wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [WB_DW-1:0]  wbs_dat_o,
    output logic              soc_reset_o,
    output logic              rom_wr_req_o,
    output logic [ROM_AW-1:0] rom_wr_addr_o,
    output logic [ROM_DW-1:0] rom_wr_data_o,
    input  logic              rom_wr_ack_i
);

    logic [1:0]        ctrl;
    logic [ROM_AW-1:0] addr;
    logic [ROM_DW-1:0] data;
    logic              terr;
    logic              start;
    logic              busy;
    logic              done_c;
    logic              timeout_c;
    rom_word_t         rom_word;

    logic [1:0]        reg_c;
    logic              hit_c;
    logic              stall_c;
    logic              accept_c;
    logic              wr_c;
    logic [WB_DW-1:0]  rd_data_c;

    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[WB_DW-1:ROM_DW]};

    assign soc_reset_o   = ctrl[CTRL_SOC_RESET];
    assign rom_wr_addr_o = rom_word.addr;
    assign rom_wr_data_o = rom_word.data;

    // Decode; the ~ack term keeps acks from landing on consecutive cycles
    assign reg_c    = wbs_adr_i[3:2];
    assign hit_c    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
                    & (wbs_adr_i[WB_DW-1:4] == BASE_ADDR[WB_DW-1:4]);
    assign stall_c  = wbs_we_i & (reg_c == REG_DATA) & busy;
    assign accept_c = hit_c & ~stall_c;
    assign wr_c     = accept_c & wbs_we_i;

    always_comb begin
        rd_data_c = '0;
        case (reg_c)
            REG_CTRL:   rd_data_c = WB_DW'(ctrl);
            REG_ADDR:   rd_data_c = WB_DW'(addr);
            REG_DATA:   rd_data_c = WB_DW'(data);
            default:    rd_data_c = WB_DW'({terr, busy});
        endcase
    end

    // Bus response and register file; an ADDR write beats the ack increment
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctrl      <= CTRL_RESET_VAL;
            addr      <= '0;
            data      <= '0;
            start     <= 1'b0;
        end else begin
            wbs_ack_o <= accept_c;
            wbs_dat_o <= accept_c ? rd_data_c : '0;
            start     <= wr_c & (reg_c == REG_DATA) & ctrl[CTRL_LOAD_MODE];
            if (wr_c && reg_c == REG_CTRL) begin
                ctrl <= wbs_dat_i[1:0];
            end
            if (wr_c && reg_c == REG_DATA) begin
                data <= wbs_dat_i[ROM_DW-1:0];
            end
            if (wr_c && reg_c == REG_ADDR) begin
                addr <= wbs_dat_i[ROM_AW-1:0];
            end else if (done_c) begin
                addr <= addr + ROM_AW'(1);
            end
        end
    end

`ifdef HACK_LOADER_TIMEOUT_EN
    // Sticky timeout flag, write-1-to-clear; a new timeout wins over the clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            terr <= 1'b0;
        end else if (timeout_c) begin
            terr <= 1'b1;
        end else if (wr_c && reg_c == REG_STATUS && wbs_dat_i[STAT_TIMEOUT]) begin
            terr <= 1'b0;
        end
    end
`else
    logic unused_to;
    assign unused_to = timeout_c;
    assign terr      = 1'b0;
`endif

    hack_loader_rom_if #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rom_if (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .start     (start),
        .word_in   ('{addr: addr, data: data}),
        .rom_ack   (rom_wr_ack_i),
        .busy      (busy),
        .req       (rom_wr_req_o),
        .word      (rom_word),
        .done_c    (done_c),
        .timeout_c (timeout_c)
    );

endmodule

// File: tb/tb_wb_hack_loader.sv
// Scoreboard bench for wb_hack_loader: expected read data and ROM requests are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_wb_hack_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_ADDR = BASE + 32'h4;
    localparam logic [31:0] A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        soc_reset;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_ack = 1'b0;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
        int          len;
    } rom_exp_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] rd_q[$];
    rom_exp_t    rom_q[$];
    rom_exp_t    cur_exp;
    bit          cur_is_read = 1'b0;
    int          ack_delay = 0;
    int          rcnt = 0;
    int          run_len = 0;
    int          stable_err = 0;
    int          done_cnt = 0;
    bit          prev_req = 1'b0;

    wb_hack_loader dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .soc_reset_o   (soc_reset),
        .rom_wr_req_o  (rom_req),
        .rom_wr_addr_o (rom_addr),
        .rom_wr_data_o (rom_data),
        .rom_wr_ack_i  (rom_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ROM side responder: acks on the ack_delay-th request cycle (0 = never)
    always @(negedge clk) begin
        if (rom_req) begin
            rcnt = rcnt + 1;
            rom_ack = (ack_delay != 0) && (rcnt == ack_delay);
        end else begin
            rcnt = 0;
            rom_ack = 1'b0;
        end
    end

    // Monitor: read data and ROM request checking against the queues
    always @(negedge clk) begin
        if (ack && cur_is_read) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'h1, 32'h0);
            else chk("rd_data", rdat, rd_q.pop_front());
        end
        if (rom_req) begin
            if (!prev_req) begin
                if (rom_q.size() == 0) begin
                    chk("rom_unexpected", 32'h1, 32'h0);
                    cur_exp = '{addr: rom_addr, data: rom_data, len: 0};
                end else begin
                    cur_exp = rom_q.pop_front();
                    chk("rom_addr", 32'(rom_addr), 32'(cur_exp.addr));
                    chk("rom_data", 32'(rom_data), 32'(cur_exp.data));
                end
                run_len = 0;
                stable_err = 0;
            end
            run_len++;
            if (rom_addr !== cur_exp.addr || rom_data !== cur_exp.data) stable_err++;
        end else if (prev_req) begin
            if (cur_exp.len != 0) chk("rom_req_len", 32'(run_len), 32'(cur_exp.len));
            chk("rom_stable", 32'(stable_err), 32'h0);
            done_cnt++;
        end
        prev_req = rom_req;
    end

    task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                             input int budget, output bit acked, output int waited);
        @(negedge clk);
        cur_is_read = !w;
        adr = a; wdat = d; we = w; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        acked = 1'b0;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (ack) begin
                acked = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        bit acked;
        int waited;
        wb_access(a, d, 1'b1, 64, acked, waited);
        chk("wr_ack", 32'(acked), 32'h1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp);
        bit acked;
        int waited;
        rd_q.push_back(exp);
        wb_access(a, 32'h0, 1'b0, 64, acked, waited);
        chk("rd_ack", 32'(acked), 32'h1);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            @(negedge clk);
        end
        chk("rom_done", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        bit acked;
        int waited;
        int d0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_soc_reset", 32'(soc_reset), 32'h1);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_req", 32'(rom_req), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rom_data", 32'(rom_data), 32'h0);
        rst_n = 1'b1;
        wb_read(A_CTRL, 32'h1);
        wb_read(A_STAT, 32'h0);
        chk("soc_reset_after_rst", 32'(soc_reset), 32'h1);

        // Basic load, acked on third request cycle
        wb_write(A_CTRL, 32'h2);
        chk("soc_reset_cleared", 32'(soc_reset), 32'h0);
        wb_write(A_ADDR, 32'h0010);
        ack_delay = 3;
        rom_q.push_back('{addr: 15'h0010, data: 16'hBEEF, len: 3});
        wb_write(A_DATA, 32'hBEEF);
        wait_done(1, 32);
        wb_read(A_ADDR, 32'h0011);
        wb_read(A_DATA, 32'hBEEF);
        wb_read(A_STAT, 32'h0);

        // Address wrap
        wb_write(A_ADDR, 32'h7FFF);
        rom_q.push_back('{addr: 15'h7FFF, data: 16'h1234, len: 3});
        wb_write(A_DATA, 32'h1234);
        wait_done(2, 32);
        wb_read(A_ADDR, 32'h0000);

        // Second DATA write while busy stalls until the ROM ack
        ack_delay = 20;
        rom_q.push_back('{addr: 15'h0000, data: 16'hAAAA, len: 20});
        wb_write(A_DATA, 32'hAAAA);
        wb_read(A_STAT, 32'h1);
        d0 = done_cnt;
        rom_q.push_back('{addr: 15'h0001, data: 16'h5555, len: 20});
        wb_access(A_DATA, 32'h5555, 1'b1, 64, acked, waited);
        chk("stall_ack", 32'(acked), 32'h1);
        chk("stall_after_done", 32'(done_cnt), 32'(d0 + 1));
        wait_done(d0 + 2, 64);
        wb_read(A_ADDR, 32'h0002);

        // load_mode=0: data latched, no request
        wb_write(A_CTRL, 32'h0);
        wb_write(A_DATA, 32'h0F0F);
        repeat (5) @(negedge clk);
        chk("no_load_req", 32'(rom_req), 32'h0);
        wb_read(A_DATA, 32'h0F0F);
        wb_read(A_ADDR, 32'h0002);
        wb_read(A_CTRL, 32'h0);

        // Outside the register window
        wb_access(BASE + 32'h10, 32'h0, 1'b0, 16, acked, waited);
        chk("oow_no_ack", 32'(acked), 32'h0);

`ifdef HACK_LOADER_TIMEOUT_EN
        // Timeout without ROM ack
        wb_write(A_CTRL, 32'h2);
        wb_write(A_ADDR, 32'h0100);
        ack_delay = 0;
        d0 = done_cnt;
        rom_q.push_back('{addr: 15'h0100, data: 16'hCAFE, len: 255});
        wb_write(A_DATA, 32'hCAFE);
        wait_done(d0 + 1, 400);
        wb_read(A_STAT, 32'h2);
        wb_read(A_ADDR, 32'h0100);
        wb_write(A_STAT, 32'h2);
        wb_read(A_STAT, 32'h0);
`endif

        // Reset in the middle of a request
        wb_write(A_CTRL, 32'h2);
        wb_write(A_ADDR, 32'h0200);
        ack_delay = 0;
        rom_q.push_back('{addr: 15'h0200, data: 16'h7777, len: 0});
        wb_write(A_DATA, 32'h7777);
        repeat (3) @(negedge clk);
        chk("req_before_rst", 32'(rom_req), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("req_drop_on_rst", 32'(rom_req), 32'h0);
        chk("soc_reset_on_rst", 32'(soc_reset), 32'h1);
        repeat (3) @(negedge clk);
        chk("req_held_low_rst", 32'(rom_req), 32'h0);
        rst_n = 1'b1;
        wb_read(A_ADDR, 32'h0000);
        wb_read(A_DATA, 32'h0000);
        wb_read(A_CTRL, 32'h1);
        wb_read(A_STAT, 32'h0);

        repeat (4) @(negedge clk);
        chk("rd_q_empty", 32'(rd_q.size()), 32'h0);
        chk("rom_q_empty", 32'(rom_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_hack_loader.md
WB_HACK_LOADER -- requirements
Module: wb_hack_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the 16-byte register window.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the ROM-ack timeout limit in clock cycles (8-bit, 1..255).
REQ-003 SHALL have port wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_n_i  in  1  asynchronous reset, active-low.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-006 SHALL have ports wbs_sel_i  in  4 and wbs_adr_i, wbs_dat_i  in  32 each  byte select, address, write data; sel is ignored and every write is full-word.
REQ-007 SHALL have ports wbs_ack_o  out  1 and wbs_dat_o  out  32  Wishbone acknowledge and read data.
REQ-008 SHALL have port soc_reset_o  out  1  hold Hack SoC in reset.
REQ-009 SHALL have ports rom_wr_req_o  out  1, rom_wr_addr_o  out  15 and rom_wr_data_o  out  16  ROM load request, word address, word data.
REQ-010 SHALL have port rom_wr_ack_i  in  1  ROM load acknowledge from SoC.

Function
REQ-011 SHALL select an access only when wbs_adr_i[31:4]==BASE_ADDR[31:4] with cyc&stb high; other accesses get no ack.
REQ-012 SHALL decode wbs_adr_i[3:2]: 0 CTRL rw ([0] soc_reset, [1] load_mode); 1 ADDR rw [14:0]; 2 DATA rw [15:0]; 3 STATUS ([0] busy ro, [1] timeout_err write-1-to-clear).
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, one cycle after a selected request is sampled, and never on two consecutive cycles.
REQ-014 SHALL drive wbs_dat_o with the zero-extended register during the ack cycle and 0 otherwise; writes to read-only bits SHALL be ignored.
REQ-015 SHALL, on a DATA write with load_mode=1 and busy=0, latch data, drive rom_wr_addr_o=ADDR and rom_wr_data_o=data, and enter R_REQ with rom_wr_req_o=1 on the cycle after the ack.
REQ-016 SHALL stall (withhold ack) a DATA write while busy=1 until R_IDLE, then complete it per REQ-015.
REQ-017 SHALL latch a DATA write with load_mode=0, ack it, and issue no request.
REQ-018 SHALL use ROM FSM states R_IDLE and R_REQ; busy = (state==R_REQ).
REQ-019 SHALL, in R_REQ, hold rom_wr_req_o, rom_wr_addr_o and rom_wr_data_o stable until rom_wr_ack_i is sampled high, then deassert req on the next cycle, return to R_IDLE and increment ADDR mod 2^15 (7FFF wraps to 0000).
REQ-020 SHALL ignore rom_wr_ack_i in R_IDLE.
REQ-021 SHALL let an ADDR write that coincides with the ack-driven increment win (written value kept).
REQ-022 SHALL drive soc_reset_o from CTRL[0]; clearing load_mode in R_REQ SHALL NOT abort the pending request.

Reset
REQ-023 SHALL, while wb_rst_n_i=0, force: wbs_ack_o=0, wbs_dat_o=0, soc_reset_o=1 (CTRL=32'h1), rom_wr_req_o=0, rom_wr_addr_o=0, rom_wr_data_o=0, ADDR=0, DATA=0, timeout_err=0, FSM=R_IDLE, timeout counter=0.
REQ-024 SHALL, on reset mid-request, drop rom_wr_req_o immediately, with no ack and no increment afterwards.

Configuration
REQ-025 SHALL, with HACK_LOADER_TIMEOUT_EN defined, count cycles in R_REQ and, when the count reaches TIMEOUT_CYCLES without ack, deassert req, set timeout_err, return to R_IDLE and not increment ADDR.
REQ-026 SHALL, without HACK_LOADER_TIMEOUT_EN, wait indefinitely in R_REQ, keep STATUS[1] reading 0 and contain no counter.

Structure
REQ-027 SHALL place register offsets, CTRL/STATUS bit indices and FSM state encoding in shared package hack_loader_pkg.
REQ-028 SHALL implement the ROM handshake FSM, including the optional timeout, in the single sub-module hack_loader_rom_if; Wishbone decode stays in the top.

Verification
REQ-029 SHALL check reset release: read CTRL -> 32'h1, STATUS -> 0, soc_reset_o=1.
REQ-030 SHALL check: CTRL=2, ADDR=0x0010, DATA=0xBEEF, rom_wr_ack_i high on the 3rd req cycle -> req held 3 cycles at addr 0x0010 / data 0xBEEF, then ADDR reads 0x0011.
REQ-031 SHALL check: ADDR=0x7FFF then an acked load -> ADDR reads 0x0000.
REQ-032 SHALL check: a second DATA write issued while busy -> ack delayed until ROM ack, then a second request with the new data.
REQ-033 SHALL check, with HACK_LOADER_TIMEOUT_EN: no ROM ack -> req drops after 255 cycles, STATUS reads 0x2, ADDR unchanged; writing STATUS=2 -> STATUS reads 0.
REQ-034 SHALL check: access at BASE_ADDR+0x10 -> no ack in 16 cycles; wb_rst_n_i low mid-request -> rom_wr_req_o=0 immediately.
